// File: rtl/arm_stream_reader_pkg.sv
// Shared constants for the translated-instruction stream reader.
package arm_stream_reader_pkg;

  localparam int          ARS_ADDRESS_WIDTH = 10;
  localparam logic [31:0] ARS_RET_WORD      = 32'hE12FFF1E;  // BX LR
  localparam int          ARS_BUF_DEPTH     = 2;

  typedef enum logic [1:0] {
    ARS_IDLE  = 2'd0,
    ARS_RUN   = 2'd1,
    ARS_DRAIN = 2'd2
  } ars_state_e;

endpackage

// File: rtl/arm_stream_buf.sv
// Two-entry FIFO between the RAM read port and the consumer handshake.
// The head register is presented directly; valid is registered and tracks
// "count != 0" after every update. The caller guarantees no push when full
// and no pop when empty.
module arm_stream_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [1:0]  count,
  output logic [31:0] head,
  output logic        valid
);

  logic [31:0] tail;
  logic [1:0]  count_nxt;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count + {1'b0, push} - {1'b0, pop};
  end

  // Storage shift and occupancy update; head always holds the oldest word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      count <= '0;
      valid <= 1'b0;
    end else begin
      count <= count_nxt;
      valid <= (count_nxt != 2'd0);
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
        end
        2'b01: head <= tail;
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/arm_stream_reader.sv
// Consumer end of the translated-instruction RAM: reads committed words in
// order, buffers them behind a valid/ready port and stops after the
// method-return word.
module arm_stream_reader
  import arm_stream_reader_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = ARS_ADDRESS_WIDTH,
  parameter logic [31:0] RET_WORD      = ARS_RET_WORD,
  parameter int          BUF_DEPTH     = ARS_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH-1:0] wr_ptr,
  output logic                     mem_rd_en,
  output logic [ADDRESS_WIDTH-1:0] mem_rd_addr,
  input  logic [31:0]              mem_rd_data,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] rd_ptr,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] inst_count
);

  ars_state_e state;
  logic       inflight;
  logic [1:0] buf_count;
  logic       accept;
  logic       ret_on_bus;
  logic       issue;
  logic [2:0] credit_used;
  logic [2:0] credit_limit;

  // Handshake, credit and stop decisions for this cycle. A pop in the same
  // cycle frees a slot before the new datum lands, which is what allows one
  // word per cycle with only two entries. A return word on the read bus
  // blocks the next issue so nothing past it is ever fetched.
  always_comb begin
    accept       = out_valid && out_ready;
    ret_on_bus   = inflight && (mem_rd_data == RET_WORD);
    credit_used  = {1'b0, buf_count} + {2'b00, inflight};
    credit_limit = 3'(BUF_DEPTH) + {2'b00, accept};
    issue        = (state == ARS_RUN) && (rd_ptr != wr_ptr) && !ret_on_bus &&
                   (credit_used < credit_limit);
    mem_rd_en    = issue;
    mem_rd_addr  = rd_ptr;
    busy         = (state != ARS_IDLE);
    done         = (state == ARS_DRAIN) && accept && (out_data == RET_WORD);
  end

  arm_stream_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     ((state == ARS_IDLE) && start),
    .push      (inflight),
    .push_data (mem_rd_data),
    .pop       (accept),
    .count     (buf_count),
    .head      (out_data),
    .valid     (out_valid)
  );

  // Sequencing FSM with read pointer, in-flight flag and accepted-word count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARS_IDLE;
      rd_ptr     <= '0;
      inflight   <= 1'b0;
      inst_count <= '0;
    end else begin
      inflight <= issue;
      if (issue)  rd_ptr     <= rd_ptr + 1'b1;
      if (accept) inst_count <= inst_count + 1'b1;
      case (state)
        ARS_IDLE: begin
          if (start) begin
            state      <= ARS_RUN;
            rd_ptr     <= base_addr;
            inst_count <= '0;
          end
        end
        ARS_RUN: begin
          if (ret_on_bus) state <= ARS_DRAIN;
        end
        ARS_DRAIN: begin
          if (done) state <= ARS_IDLE;
        end
        default: state <= ARS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_stream_reader.sv
// Self-checking bench for arm_stream_reader: directed scenarios plus random
// streams compared against an expected word list built from RAM contents.
module tb_arm_stream_reader;

  localparam logic [31:0] RET = 32'hE12FFF1E;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start4;
  logic [9:0]  base_addr, wr_ptr, mem_rd_addr, rd_ptr, inst_count;
  logic [3:0]  base4, wr4, addr4, rd_ptr4, inst4;
  logic        mem_rd_en, en4;
  logic [31:0] mem_rd_data, data4, out_data, out4;
  logic        out_valid, out_ready, busy, done;
  logic        valid4, ready4, busy4, done4;

  always #5 clk = ~clk;

  arm_stream_reader #(.ADDRESS_WIDTH(10)) u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .wr_ptr(wr_ptr), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .rd_ptr(rd_ptr), .busy(busy), .done(done),
    .inst_count(inst_count)
  );

  arm_stream_reader #(.ADDRESS_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .base_addr(base4),
    .wr_ptr(wr4), .mem_rd_en(en4), .mem_rd_addr(addr4),
    .mem_rd_data(data4), .out_data(out4), .out_valid(valid4),
    .out_ready(ready4), .rd_ptr(rd_ptr4), .busy(busy4), .done(done4),
    .inst_count(inst4)
  );

  logic [31:0] ram  [0:1023];
  logic [31:0] ram4 [0:15];

  always @(posedge clk) if (en4)      data4       <= ram4[addr4];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  int checks = 0, errors = 0;
  int rd_cnt, done_cnt, done_bad, rd_cnt4, done_cnt4;
  logic [31:0] acc_q[$], rd_addr_q[$], acc4_q[$], rd_addr4_q[$];
  bit rnd_ready = 0;

  // Transaction log of both DUTs.
  always @(posedge clk) begin
    if (reset) begin
      if (mem_rd_en) begin rd_cnt++; rd_addr_q.push_back(32'(mem_rd_addr)); end
      if (out_valid && out_ready) acc_q.push_back(out_data);
      if (done) begin
        done_cnt++;
        if (!(out_valid && out_ready && out_data == RET)) done_bad++;
      end
      if (en4) begin rd_cnt4++; rd_addr4_q.push_back(32'(addr4)); end
      if (valid4 && ready4) acc4_q.push_back(out4);
      if (done4) done_cnt4++;
    end
  end

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == RET) w = 32'h0;
    return w;
  endfunction

  function automatic bit q_match(input logic [31:0] a[$], input logic [31:0] b[$]);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] !== b[i]) return 0;
    return 1;
  endfunction

  task automatic clear_logs();
    rd_cnt = 0; done_cnt = 0; rd_cnt4 = 0; done_cnt4 = 0;
    acc_q.delete(); rd_addr_q.delete(); acc4_q.delete(); rd_addr4_q.delete();
  endtask

  task automatic pulse_start(input logic [9:0] b);
    @(negedge clk); base_addr = b; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int c0;
    c0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > c0) begin ok = 1; break; end
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; start4 = 0; out_ready = 0; ready4 = 0;
    base_addr = '0; wr_ptr = '0; base4 = '0; wr4 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({out_valid, out_data, mem_rd_en, mem_rd_addr, busy, done, inst_count, rd_ptr} !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h en=%b addr=%h busy=%b done=%b cnt=%h rd_ptr=%h, want all 0",
               out_valid, out_data, mem_rd_en, mem_rd_addr, busy, done, inst_count, rd_ptr);
    end
    checks++;
    if ({valid4, out4, en4, addr4, busy4, done4, inst4, rd_ptr4} !== '0) begin
      errors++;
      $display("FAIL reset4: outputs of 4-bit instance not zero");
    end
  endtask

  task automatic load_basic();
    ram[10'h010] = 32'hE3A00001;
    ram[10'h011] = 32'hE3A01002;
    ram[10'h012] = RET;
    wr_ptr = 10'h013;
  endtask

  task automatic test_basic();
    load_basic();
    rnd_ready = 0; out_ready = 1;
    clear_logs();
    pulse_start(10'h010);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_latency: valid=%b busy=%b, want 0 1", out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hE3A00001) begin
      errors++; $display("FAIL basic_w0: valid=%b data=%h, want 1 E3A00001", out_valid, out_data);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hE3A01002) begin
      errors++; $display("FAIL basic_w1: valid=%b data=%h, want 1 E3A01002", out_valid, out_data);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== RET || done !== 1'b1) begin
      errors++; $display("FAIL basic_w2: valid=%b data=%h done=%b, want 1 %h 1", out_valid, out_data, done, RET);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || inst_count !== 10'd3 || out_valid !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL basic_end: busy=%b cnt=%0d valid=%b dones=%0d, want 0 3 0 1",
                         busy, inst_count, out_valid, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp[$];
    load_basic();
    exp = '{32'hE3A00001, 32'hE3A01002, RET};
    rnd_ready = 0; out_ready = 0;
    clear_logs();
    pulse_start(10'h010);
    repeat (10) @(negedge clk);
    checks++;
    if (rd_cnt != 2 || rd_ptr !== 10'h012) begin
      errors++; $display("FAIL bp_stall: reads=%0d rd_ptr=%h, want 2 012", rd_cnt, rd_ptr);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hE3A00001 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_head: valid=%b data=%h busy=%b, want 1 E3A00001 1", out_valid, out_data, busy);
    end
    out_ready = 1;
    wait_done(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: done=0, want 1"); end
    checks++;
    if (!q_match(acc_q, exp) || inst_count !== 10'd3) begin
      errors++; $display("FAIL bp_words: got %0d words cnt=%0d, want 3 in order", acc_q.size(), inst_count);
    end
  endtask

  task automatic test_starved();
    logic [31:0] w[3];
    w[0] = rnd_word(); w[1] = rnd_word(); w[2] = RET;
    for (int i = 0; i < 3; i++) ram[10'h040 + i] = w[i];
    wr_ptr = 10'h040; rnd_ready = 0; out_ready = 1;
    clear_logs();
    pulse_start(10'h040);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL starve_wait: valid=%b busy=%b, want 0 1", out_valid, busy);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); wr_ptr = 10'(10'h040 + k + 1);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL starve_pre%0d: valid=%b busy=%b, want 0 1", k, out_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[k] || busy !== 1'b1) begin
        errors++; $display("FAIL starve_w%0d: valid=%b data=%h busy=%b, want 1 %h 1",
                           k, out_valid, out_data, busy, w[k]);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== (k != 2)) begin
        errors++; $display("FAIL starve_post%0d: valid=%b busy=%b, want 0 %b", k, out_valid, busy, k != 2);
      end
    end
    checks++;
    if (rd_ptr !== 10'h043 || inst_count !== 10'd3 || done_cnt != 1) begin
      errors++; $display("FAIL starve_end: rd_ptr=%h cnt=%0d dones=%0d, want 043 3 1", rd_ptr, inst_count, done_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w[$], exp_a[$];
    ram4[14] = rnd_word(); ram4[15] = rnd_word(); ram4[0] = RET; ram4[1] = rnd_word();
    exp_w = '{ram4[14], ram4[15], RET};
    exp_a = '{32'd14, 32'd15, 32'd0};
    wr4 = 4'h1; ready4 = 1;
    clear_logs();
    @(negedge clk); base4 = 4'hE; start4 = 1;
    @(negedge clk); start4 = 0;
    for (int i = 0; i < 30 && done_cnt4 == 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (!q_match(rd_addr4_q, exp_a)) begin
      errors++; $display("FAIL wrap_reads: %0d reads, want 3 at E,F,0", rd_addr4_q.size());
    end
    checks++;
    if (rd_ptr4 !== 4'h1 || done_cnt4 != 1 || !q_match(acc4_q, exp_w)) begin
      errors++; $display("FAIL wrap_end: rd_ptr=%h dones=%0d words=%0d, want 1 1 3", rd_ptr4, done_cnt4, acc4_q.size());
    end
  endtask

  task automatic test_early_return();
    bit ok;
    logic [31:0] exp[$];
    for (int i = 0; i < 5; i++) ram[10'h100 + i] = rnd_word();
    ram[10'h101] = RET;
    exp = '{ram[10'h100], RET};
    wr_ptr = 10'h105; rnd_ready = 0; out_ready = 1;
    clear_logs();
    pulse_start(10'h100);
    wait_done(20, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || rd_cnt != 2 || rd_ptr !== 10'h102) begin
      errors++; $display("FAIL early_reads: done=%b reads=%0d rd_ptr=%h, want 1 2 102", ok, rd_cnt, rd_ptr);
    end
    checks++;
    if (inst_count !== 10'd2 || !q_match(acc_q, exp)) begin
      errors++; $display("FAIL early_words: cnt=%0d words=%0d, want 2 2", inst_count, acc_q.size());
    end
  endtask

  task automatic test_midrun_reset();
    bit ok;
    logic [31:0] exp[$];
    ram[10'h200] = rnd_word(); ram[10'h201] = rnd_word(); ram[10'h202] = RET;
    exp = '{ram[10'h200], ram[10'h201], RET};
    wr_ptr = 10'h203; rnd_ready = 0; out_ready = 0;
    clear_logs();
    pulse_start(10'h200);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || rd_cnt != 2) begin
      errors++; $display("FAIL mid_setup: valid=%b reads=%0d, want 1 2", out_valid, rd_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({out_valid, out_data, mem_rd_en, mem_rd_addr, busy, done, inst_count, rd_ptr} !== '0) begin
      errors++; $display("FAIL mid_reset: valid=%b data=%h en=%b busy=%b cnt=%h rd_ptr=%h, want all 0",
                         out_valid, out_data, mem_rd_en, busy, inst_count, rd_ptr);
    end
    out_ready = 1;
    clear_logs();
    pulse_start(10'h200);
    wait_done(20, ok);
    checks++;
    if (!ok || !q_match(acc_q, exp) || inst_count !== 10'd3) begin
      errors++; $display("FAIL mid_replay: done=%b words=%0d cnt=%0d, want 1 3 3", ok, acc_q.size(), inst_count);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [9:0] b;
    int len, extra;
    logic [31:0] exp[$], exp_a[$];
    rnd_ready = 1;
    for (int it = 0; it < 25; it++) begin
      b = 10'($urandom); len = $urandom_range(1, 6); extra = $urandom_range(0, 3);
      exp.delete(); exp_a.delete();
      for (int i = 0; i < len + extra; i++) ram[10'(b + i)] = rnd_word();
      ram[10'(b + len - 1)] = RET;
      for (int i = 0; i < len; i++) begin
        exp.push_back(ram[10'(b + i)]);
        exp_a.push_back(32'(10'(b + i)));
      end
      wr_ptr = 10'(b + len + extra);
      clear_logs();
      pulse_start(b);
      wait_done(300, ok);
      checks++;
      if (!ok || !q_match(acc_q, exp) || !q_match(rd_addr_q, exp_a)) begin
        errors++; $display("FAIL rand%0d_seq: done=%b words=%0d reads=%0d, want 1 %0d %0d",
                           it, ok, acc_q.size(), rd_addr_q.size(), len, len);
      end
      checks++;
      if (rd_ptr !== 10'(b + len) || inst_count !== 10'(len) || busy !== 1'b0) begin
        errors++; $display("FAIL rand%0d_end: rd_ptr=%h cnt=%0d busy=%b, want %h %0d 0",
                           it, rd_ptr, inst_count, busy, 10'(b + len), len);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    done_bad = 0;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 16; i++) ram4[i] = '0;
    clear_logs();
    test_reset();
    test_basic();
    test_backpressure();
    test_starved();
    test_wrap();
    test_early_return();
    test_midrun_reset();
    test_random();
    checks++;
    if (done_bad != 0) begin
      errors++; $display("FAIL done_align: %0d done pulses without RET accept, want 0", done_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
